// File: rtl/data_mem_lsu_pkg.sv
// Shared RV32I load/store encodings and the lane-steering helpers used by the
// LSU: access sizing, byte-enable generation, store replication, load extension.
package data_mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } acc_size_e;

  function automatic acc_size_e f3_size(input logic [2:0] f3);
    acc_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      F3_W:        sz = SZ_WORD;
      default:     sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  // Halfword offsets are assumed even; odd ones are faulted before use.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3_size(f3))
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (f3_size(f3))
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [1:0] off);
    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    shifted = word >> {off, 3'b000};
    b_s     = shifted[7:0];
    h_s     = shifted[15:0];
    case (f3)
      F3_B:    ext_s = b_s;
      F3_H:    ext_s = h_s;
      F3_W:    ext_s = word;
      F3_BU:   ext_s = {24'd0, shifted[7:0]};
      F3_HU:   ext_s = {16'd0, shifted[15:0]};
      default: ext_s = '0;
    endcase
    return ext_s;
  endfunction

endpackage

// File: rtl/data_mem_lsu_dmem_bank.sv
// Byte-enabled word array: write on the rising edge, read asynchronously.
// Contents are intentionally not reset.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < 4; l++) begin
        if (i_be[l]) r_mem[i_idx][l*8 +: 8] <= i_wdata[l*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit wrapping the data bank: address range and alignment checks,
// lane steering and extension, plus a sticky first-fault recorder.
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic        i_mem_re,
  input  logic        i_mem_we,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_out_of_range,
  output logic        o_fault_valid,
  output logic [31:0] o_fault_addr,
  output logic        o_fault_is_store,
  input  logic        i_fault_clr
);

  logic [32:0]       w_off;
  logic              w_underflow;
  logic              w_beyond;
  logic              w_access;
  logic              w_mis_raw;
  logic              w_fault;
  logic [ADDR_W-1:0] w_widx;
  logic [1:0]        w_byte_off;
  logic              w_bank_we;
  logic [3:0]        w_be;
  logic [31:0]       w_lanes;
  logic [31:0]       w_word;

  // One extra bit catches addresses below BASE_ADDR instead of letting them wrap.
  assign w_off       = {1'b0, i_addr} - {1'b0, BASE_ADDR};
  assign w_underflow = w_off[32];
  assign w_beyond    = (w_off[31:0] >> (ADDR_W + 2)) != 32'd0;
  assign w_widx      = w_off[ADDR_W+1:2];
  assign w_byte_off  = w_off[1:0];

  always_comb begin
    w_mis_raw = 1'b0;
    case (f3_size(i_funct3))
      SZ_HALF: w_mis_raw = i_addr[0];
      SZ_WORD: w_mis_raw = |i_addr[1:0];
      SZ_NONE: w_mis_raw = 1'b1;
      default: w_mis_raw = 1'b0;
    endcase
  end

  assign w_access       = i_mem_re | i_mem_we;
  assign o_misaligned   = w_access & w_mis_raw;
  assign o_out_of_range = w_access & (w_underflow | w_beyond);
  assign w_fault        = o_misaligned | o_out_of_range;

  assign w_bank_we = i_mem_we & ~w_fault & i_rst_n;
  assign w_be      = byte_en(i_funct3, w_byte_off);
  assign w_lanes   = store_lanes(i_funct3, i_wdata);

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_bank (
    .i_clk   (i_clk),
    .i_we    (w_bank_we),
    .i_be    (w_be),
    .i_idx   (w_widx),
    .i_wdata (w_lanes),
    .o_rdata (w_word)
  );

  // Read path sees pre-write contents since the bank only updates at the edge.
  assign o_rdata = (i_mem_re & ~w_fault) ? load_ext(i_funct3, w_word, w_byte_off) : 32'd0;

  // fault recorder: clear wins over capture; first fault holds until cleared
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_fault_valid    <= 1'b0;
      o_fault_addr     <= 32'd0;
      o_fault_is_store <= 1'b0;
    end else if (i_fault_clr) begin
      o_fault_valid    <= 1'b0;
      o_fault_addr     <= 32'd0;
      o_fault_is_store <= 1'b0;
    end else if (w_fault && !o_fault_valid) begin
      o_fault_valid    <= 1'b1;
      o_fault_addr     <= i_addr;
      o_fault_is_store <= i_mem_we;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed vector table for the documented scenarios,
// then random traffic compared against a byte-array reference model.
module tb_data_mem_lsu;

  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          SPAN  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n, re, we, clr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, fa;
  logic        mis, oor, fv, fs;

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_funct3(f3),
    .i_mem_re(re), .i_mem_we(we), .o_rdata(rdata), .o_misaligned(mis),
    .o_out_of_range(oor), .o_fault_valid(fv), .o_fault_addr(fa),
    .o_fault_is_store(fs), .i_fault_clr(clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: flat byte memory plus the fault record.
  logic [7:0]  m_mem [SPAN];
  logic        m_fv = 1'b0;
  logic [31:0] m_fa = 32'd0;
  logic        m_fs = 1'b0;
  logic        m_fault;
  logic [31:0] e_rd;
  logic        e_mis, e_oor;

  function automatic int size_of(input logic [2:0] c);
    case (c)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  task automatic model_comb();
    longint a = longint'(addr);
    int sz = size_of(f3);
    int idx;
    logic active = re | we;
    logic [31:0] v = 32'd0;
    e_oor = active && !((a >= longint'(BASE)) && (a < longint'(BASE) + SPAN));
    e_mis = active && ((sz == 0) || ((a % sz) != 0));
    m_fault = e_oor | e_mis;
    e_rd = 32'd0;
    if (re && !m_fault) begin
      idx = int'(a - longint'(BASE));
      for (int i = 0; i < sz; i++) v = v | (32'(m_mem[idx + i]) << (8 * i));
      if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
      e_rd = v;
    end
  endtask

  task automatic model_edge();
    int sz = size_of(f3);
    int idx;
    if (!rst_n) begin
      m_fv = 1'b0; m_fa = 32'd0; m_fs = 1'b0;
    end else begin
      if (we && !m_fault) begin
        idx = int'(longint'(addr) - longint'(BASE));
        for (int i = 0; i < sz; i++) m_mem[idx + i] = wdata[8*i +: 8];
      end
      if (clr) begin
        m_fv = 1'b0; m_fa = 32'd0; m_fs = 1'b0;
      end else if (m_fault && !m_fv) begin
        m_fv = 1'b1; m_fa = addr; m_fs = we;
      end
    end
  endtask

  task automatic apply(input logic r, input logic re_i, input logic we_i, input logic clr_i,
                       input logic [2:0] f3_i, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    rst_n = r; re = re_i; we = we_i; clr = clr_i; f3 = f3_i; addr = a; wdata = wd;
    #1;
    model_comb();
  endtask

  task automatic commit();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        rst_n, re, we, clr;
    logic [2:0]  f3;
    logic [31:0] off, wdata, exp_rd;
    logic        exp_mis, exp_oor, exp_fv;
    logic [31:0] exp_fa;
    logic        exp_fs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rd, input logic wr, input logic c,
                              input logic [2:0] fc, input logic [31:0] o, input logic [31:0] wd,
                              input logic [31:0] erd, input logic emis, input logic eoor,
                              input logic efv, input logic [31:0] efa, input logic efs);
    vec_t v;
    v.rst_n = r; v.re = rd; v.we = wr; v.clr = c; v.f3 = fc; v.off = o; v.wdata = wd;
    v.exp_rd = erd; v.exp_mis = emis; v.exp_oor = eoor;
    v.exp_fv = efv; v.exp_fa = efa; v.exp_fs = efs;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_fa_abs;
    int r;
    logic [2:0] rf3;
    logic [31:0] ra;
    logic rre, rwe;

    rst_n = 1'b0; re = 1'b0; we = 1'b0; clr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, BASE, 32'd0);
      commit();
    end
    chk("reset fault_valid", {31'd0, fv}, 32'd0);
    chk("reset fault_addr", fa, 32'd0);
    chk("reset fault_is_store", {31'd0, fs}, 32'd0);

    // Give every word a known value so the model never reads uninitialised bytes
    for (int w = 0; w < DEPTH; w++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, BASE + 32'(4 * w), $urandom);
      commit();
    end

    //       rst re we clr f3    off            wdata         exp_rd        mis  oor  fv   fa     fs
    tbl.push_back(mk(1, 0, 1, 0, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd2, 32'h10, 32'h0,        32'h0,        0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd0, 32'h13, 32'h12345680, 32'h0,        0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd4, 32'h13, 32'h0,        32'h00000080, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h10, 32'h0,        32'h80000000, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd2, 32'h20, 32'h0,        32'h0,        0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd1, 32'h22, 32'hABCD8001, 32'h0,        0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd1, 32'h22, 32'h0,        32'hFFFF8001, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd5, 32'h22, 32'h0,        32'h00008001, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h20, 32'h0,        32'h80010000, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd2, 32'hFFC, 32'hCAFEF00D, 32'h0,       0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'hFFC, 32'h0,       32'hCAFEF00D, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd2, 32'h30, 32'h11223344, 32'h0,        0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd2, 32'h31, 32'h12345678, 32'h0,        1, 0, 1, 32'h31, 1));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h30, 32'h0,        32'h11223344, 0, 0, 1, 32'h31, 1));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h1000, 32'h0,      32'h0,        0, 1, 1, 32'h31, 1));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h5,  32'h0,        32'h0,        1, 0, 1, 32'h31, 1));
    tbl.push_back(mk(1, 1, 0, 0, 3'd0, 32'hFFFFFFFC, 32'h0,  32'h0,        0, 1, 1, 32'h31, 1));
    tbl.push_back(mk(1, 1, 0, 1, 3'd1, 32'h7,  32'h0,        32'h0,        1, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h5,  32'h0,        32'h0,        1, 0, 1, 32'h5,  0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd2, 32'h40, 32'h55555555, 32'h0,        0, 0, 1, 32'h5,  0));
    tbl.push_back(mk(0, 0, 1, 0, 3'd2, 32'h40, 32'hAAAAAAAA, 32'h0,        0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h40, 32'h0,        32'h55555555, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd3, 32'h40, 32'h0,        32'h0,        1, 0, 1, 32'h40, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'd2, 32'h40, 32'h0,        32'h0,        0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 3'd2, 32'h40, 32'h99999999, 32'h55555555, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 3'd2, 32'h40, 32'h0,        32'h99999999, 0, 0, 0, 32'h0,  0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst_n, tbl[i].re, tbl[i].we, tbl[i].clr, tbl[i].f3,
            BASE + tbl[i].off, tbl[i].wdata);
      chk($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d misaligned", i), {31'd0, mis}, {31'd0, tbl[i].exp_mis});
      chk($sformatf("vec%0d out_of_range", i), {31'd0, oor}, {31'd0, tbl[i].exp_oor});
      commit();
      exp_fa_abs = tbl[i].exp_fv ? BASE + tbl[i].exp_fa : 32'd0;
      chk($sformatf("vec%0d fault_valid", i), {31'd0, fv}, {31'd0, tbl[i].exp_fv});
      chk($sformatf("vec%0d fault_addr", i), fa, exp_fa_abs);
      chk($sformatf("vec%0d fault_is_store", i), {31'd0, fs}, {31'd0, tbl[i].exp_fs});
    end

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 15);
      rre = (r < 7) || (r == 15);
      rwe = (r >= 7 && r < 13) || (r == 15);
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 15))
        0:       ra = BASE - 32'($urandom_range(1, 16));
        1:       ra = BASE + SPAN + 32'($urandom_range(0, 16));
        2, 3:    ra = BASE + 32'($urandom_range(0, SPAN - 1));
        default: ra = BASE + 32'($urandom_range(0, 255));
      endcase
      apply(($urandom_range(0, 63) != 0), rre, rwe, ($urandom_range(0, 15) == 0), rf3, ra, $urandom);
      chk("rand rdata", rdata, e_rd);
      chk("rand misaligned", {31'd0, mis}, {31'd0, e_mis});
      chk("rand out_of_range", {31'd0, oor}, {31'd0, e_oor});
      commit();
      chk("rand fault_valid", {31'd0, fv}, {31'd0, m_fv});
      chk("rand fault_addr", fa, m_fa);
      chk("rand fault_is_store", {31'd0, fs}, {31'd0, m_fs});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
